// File: rtl/set_assoc_icache_if.sv
// Handshake bundle for set_assoc_icache: fetch request/response plus the line-refill
// memory bus. The cache takes the slave modport; the fetch stage / memory side takes master.
interface set_assoc_icache_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_DATA_WIDTH = 32
);
  logic                      fetch_valid;
  logic [ADDR_WIDTH-1:0]     fetch_addr;
  logic                      fetch_ready;
  logic [31:0]               instr;
  logic                      instr_valid;
  logic                      invalidate;
  logic                      mem_req_valid;
  logic [ADDR_WIDTH-1:0]     mem_req_addr;
  logic                      mem_req_ready;
  logic                      mem_resp_valid;
  logic [MEM_DATA_WIDTH-1:0] mem_resp_data;

  modport master (
    output fetch_valid, fetch_addr, invalidate, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  fetch_ready, instr, instr_valid, mem_req_valid, mem_req_addr
  );

  modport slave (
    input  fetch_valid, fetch_addr, invalidate, mem_req_ready, mem_resp_valid, mem_resp_data,
    output fetch_ready, instr, instr_valid, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/set_assoc_icache.sv
// N-way set-associative read-only instruction cache with tree-PLRU replacement and
// multi-beat line refill. Define ICACHE_STATS_EN to add saturating hit/miss counters.
module set_assoc_icache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WAYS           = 2,
  parameter int SETS           = 64,
  parameter int LINE_BYTES     = 64,
  parameter int MEM_DATA_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  set_assoc_icache_if.slave   bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]         hit_count_o,
  output logic [31:0]         miss_count_o
`endif
);

  localparam int OFFSET_W     = $clog2(LINE_BYTES);
  localparam int INDEX_W      = $clog2(SETS);
  localparam int TAG_W        = ADDR_WIDTH - OFFSET_W - INDEX_W;
  localparam int BEATS        = LINE_BYTES * 8 / MEM_DATA_WIDTH;
  localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BYTES_W = $clog2(MEM_DATA_WIDTH / 8);
  localparam int WAY_W        = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LEVELS       = $clog2(WAYS);
  localparam int PLRU_W       = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, REFILL} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:2]     addr_q;
  logic [WAY_W-1:0]          victim_q, victim_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic                      inv_pend_q, inv_pend_d;

  logic [MEM_DATA_WIDTH-1:0] data_q  [WAYS][SETS][BEATS];
  logic [TAG_W-1:0]          tag_q   [WAYS][SETS];
  logic [WAYS-1:0]           valid_q [SETS];
  logic [PLRU_W-1:0]         plru_q  [SETS];

  logic [INDEX_W-1:0]        index;
  logic [TAG_W-1:0]          tag;
  logic                      hit;
  logic [WAY_W-1:0]          hit_way;
  logic [WAY_W-1:0]          victim_c;
  logic [BEAT_W-1:0]         beat_sel;
  logic [MEM_DATA_WIDTH-1:0] hit_beat;
  logic [31:0]               hit_word;

  logic fetch_rdy, instr_vld, req_vld;
  logic lookup_hit, refill_we, refill_last, clear_all;
  logic addr_lsb_unused;

  assign addr_lsb_unused = ^bus.fetch_addr[1:0];

  assign index = addr_q[OFFSET_W +: INDEX_W];
  assign tag   = addr_q[ADDR_WIDTH-1 -: TAG_W];

  // Heap-ordered tree: node n lives at bit n-1; a 0 bit steers the victim to the lower half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int node;
    node = 1;
    for (int l = 0; l < LEVELS; l++) node = 2 * node + int'(bits[node-1]);
    return WAY_W'(node - WAYS);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] res;
    logic              dir;
    int                node;
    res  = bits;
    node = 1;
    for (int l = 0; l < LEVELS; l++) begin
      dir         = way[LEVELS-1-l];
      res[node-1] = ~dir;
      node        = 2 * node + int'(dir);
    end
    return res;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[index][w] && (tag_q[w][index] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    victim_c = plru_victim(plru_q[index]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[index][w]) victim_c = WAY_W'(w);
    end
  end

  generate
    if (BEATS > 1) begin : g_beat_sel
      assign beat_sel = addr_q[OFFSET_W-1:BEAT_BYTES_W];
    end else begin : g_one_beat
      assign beat_sel = '0;
    end
  endgenerate

  assign hit_beat = data_q[hit_way][index][beat_sel];

  generate
    if (MEM_DATA_WIDTH == 64) begin : g_word64
      assign hit_word = addr_q[2] ? hit_beat[63:32] : hit_beat[31:0];
    end else begin : g_word32
      assign hit_word = hit_beat[31:0];
    end
  endgenerate

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    beat_d      = beat_q;
    inv_pend_d  = inv_pend_q;
    fetch_rdy   = 1'b0;
    instr_vld   = 1'b0;
    req_vld     = 1'b0;
    lookup_hit  = 1'b0;
    refill_we   = 1'b0;
    refill_last = 1'b0;
    clear_all   = 1'b0;
    unique case (state_q)
      IDLE: begin
        fetch_rdy = !bus.invalidate;
        clear_all = bus.invalidate;
        if (bus.fetch_valid && fetch_rdy) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (bus.invalidate) begin
          // Suppressed hit or miss alike: stay here and replay against the cleared set.
          clear_all = 1'b1;
        end else if (hit) begin
          lookup_hit = 1'b1;
          instr_vld  = 1'b1;
          fetch_rdy  = 1'b1;
          state_d    = bus.fetch_valid ? LOOKUP : IDLE;
        end else begin
          victim_d = victim_c;
          state_d  = MISS_REQ;
        end
      end
      MISS_REQ: begin
        req_vld = 1'b1;
        if (bus.invalidate) inv_pend_d = 1'b1;
        if (bus.mem_req_ready) state_d = REFILL;
      end
      REFILL: begin
        if (bus.invalidate) inv_pend_d = 1'b1;
        if (bus.mem_resp_valid) begin
          refill_we = 1'b1;
          beat_d    = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            refill_last = 1'b1;
            clear_all   = inv_pend_q || bus.invalidate;
            inv_pend_d  = 1'b0;
            beat_d      = '0;
            state_d     = LOOKUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fetch_ready   = fetch_rdy;
  assign bus.instr_valid   = instr_vld;
  assign bus.instr         = instr_vld ? hit_word : 32'd0;
  assign bus.mem_req_valid = req_vld;
  assign bus.mem_req_addr  = req_vld ? {addr_q[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}} : '0;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      victim_q   <= '0;
      beat_q     <= '0;
      inv_pend_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      beat_q     <= beat_d;
      inv_pend_q <= inv_pend_d;
      if (bus.fetch_valid && fetch_rdy) addr_q <= bus.fetch_addr[ADDR_WIDTH-1:2];
      if (clear_all) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (refill_last) begin
        valid_q[index][victim_q] <= 1'b1;
      end
      if (lookup_hit)       plru_q[index] <= plru_touch(plru_q[index], hit_way);
      else if (refill_last) plru_q[index] <= plru_touch(plru_q[index], victim_q);
    end
  end

  // NOTE: tag and data arrays carry no reset; valid bits alone gate their contents.
  always_ff @(posedge clk_i) begin
    if (refill_we)   data_q[victim_q][index][beat_q] <= bus.mem_resp_data;
    if (refill_last) tag_q[victim_q][index]          <= tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        replay_q;
  logic        miss_evt;

  assign miss_evt = (state_q == LOOKUP) && !bus.invalidate && !hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      replay_q   <= 1'b0;
    end else begin
      // The hit that completes a refill replay was already counted as a miss.
      if (refill_last)     replay_q <= 1'b1;
      else if (lookup_hit) replay_q <= 1'b0;
      if (lookup_hit && !replay_q && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF))               miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule
